// File: rtl/pe_ws_vector_if.sv
// pe_ws_vector_if
// Purpose: daisy-chain bus between weight-stationary vector PEs. The same
// bundle carries the weight-load stream and the ifmap/psum compute stream,
// so one PE's output bus plugs straight into the next PE's input bus.
// Signals:
//   wload_valid  weight beat valid
//   weight       signed weight beat
//   valid        ifmap/psum beat valid
//   ifmap        packed signed ifmap vector, lane 0 in the LSBs
//   psum         signed partial sum
// Modports: master drives the bus, slave receives it.
interface pe_ws_vector_if #(
  parameter int IFMAP_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANES        = 4,
  parameter int PSUM_WIDTH   = 21
);
  logic                            wload_valid;
  logic signed [WEIGHT_WIDTH-1:0]  weight;
  logic                            valid;
  logic [LANES*IFMAP_WIDTH-1:0]    ifmap;
  logic signed [PSUM_WIDTH-1:0]    psum;

  modport master (output wload_valid, output weight, output valid,
                  output ifmap, output psum);
  modport slave  (input wload_valid, input weight, input valid,
                  input ifmap, input psum);
endinterface

// File: rtl/pe_ws_vector.sv
// pe_ws_vector
// Purpose: weight-stationary processing element holding LANES signed weights.
// Weights are shifted in one beat at a time (EMPTY -> LOADING -> READY); once
// READY, further weight beats are forwarded down the chain one cycle later and
// every valid ifmap beat produces psum_in + dot(ifmap, weights) one cycle later.
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   wclear_i   discard stored weights and return to EMPTY
//   chain_i    incoming weight stream and ifmap/psum beats (slave)
//   chain_o    forwarded weight stream and registered results (master)
//   sat_o      result clamped this beat (only possible when SATURATE=1)
//   ready_o    high while all weights are loaded
module pe_ws_vector #(
  parameter int IFMAP_WIDTH        = 8,
  parameter int WEIGHT_WIDTH       = 8,
  parameter int LANES              = 4,
  parameter int ACCUMULATION_WIDTH = 3,
  parameter int PSUM_WIDTH         = IFMAP_WIDTH + WEIGHT_WIDTH +
                                     ACCUMULATION_WIDTH + $clog2(LANES),
  parameter bit SATURATE           = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wclear_i,
  pe_ws_vector_if.slave         chain_i,
  pe_ws_vector_if.master        chain_o,
  output logic                  sat_o,
  output logic                  ready_o
);

  localparam int PROD_W = IFMAP_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
  // One bit wider than either addend so psum_i + dot never overflows.
  localparam int EXT_W  = ((SUM_W > PSUM_WIDTH) ? SUM_W : PSUM_WIDTH) + 1;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic signed [EXT_W-1:0] PMAX =
    {{(EXT_W-PSUM_WIDTH+1){1'b0}}, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] PMIN =
    {{(EXT_W-PSUM_WIDTH+1){1'b1}}, {(PSUM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic signed [WEIGHT_WIDTH-1:0]  weights_q [LANES];
  logic signed [WEIGHT_WIDTH-1:0]  weights_d [LANES];
  logic                            wfwd_valid_q, wfwd_valid_d;
  logic signed [WEIGHT_WIDTH-1:0]  wfwd_q, wfwd_d;

  logic                            valid_q, valid_d;
  logic [LANES*IFMAP_WIDTH-1:0]    ifmap_q, ifmap_d;
  logic signed [PSUM_WIDTH-1:0]    psum_q, psum_d;
  logic                            sat_q, sat_d;

  logic signed [IFMAP_WIDTH-1:0]   lane_v;
  logic signed [PROD_W-1:0]        prod;
  logic signed [SUM_W-1:0]         dot;
  logic signed [EXT_W-1:0]         exact;

  // Weight loader FSM and forwarding path. wclear_i wins over any weight
  // beat in the same cycle, so that beat is neither stored nor forwarded.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    weights_d    = weights_q;
    wfwd_valid_d = 1'b0;
    wfwd_d       = '0;
    if (wclear_i) begin
      state_d   = EMPTY;
      cnt_d     = '0;
      weights_d = '{default: '0};
    end else if (chain_i.wload_valid) begin
      case (state_q)
        EMPTY: begin
          weights_d[0] = chain_i.weight;
          if (LANES == 1) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            state_d = LOADING;
            cnt_d   = CNT_W'(1);
          end
        end
        LOADING: begin
          weights_d[cnt_q] = chain_i.weight;
          if (cnt_q == CNT_W'(LANES - 1)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        READY: begin
          wfwd_valid_d = 1'b1;
          wfwd_d       = chain_i.weight;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Full-precision signed dot product plus sign-extended psum_i, then wrap
  // or clamp to PSUM_WIDTH. Beats outside READY (or during a clear) are dropped.
  always_comb begin
    lane_v  = '0;
    prod    = '0;
    dot     = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_v = chain_i.ifmap[l*IFMAP_WIDTH +: IFMAP_WIDTH];
      prod   = $signed({{WEIGHT_WIDTH{lane_v[IFMAP_WIDTH-1]}}, lane_v}) *
               $signed({{IFMAP_WIDTH{weights_q[l][WEIGHT_WIDTH-1]}}, weights_q[l]});
      dot    = dot + $signed({{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod});
    end
    exact = $signed({{(EXT_W-SUM_W){dot[SUM_W-1]}}, dot}) +
            $signed({{(EXT_W-PSUM_WIDTH){chain_i.psum[PSUM_WIDTH-1]}}, chain_i.psum});

    valid_d = 1'b0;
    ifmap_d = '0;
    psum_d  = '0;
    sat_d   = 1'b0;
    if (chain_i.valid && (state_q == READY) && !wclear_i) begin
      valid_d = 1'b1;
      ifmap_d = chain_i.ifmap;
      if (SATURATE && (exact > PMAX)) begin
        psum_d = PMAX[PSUM_WIDTH-1:0];
        sat_d  = 1'b1;
      end else if (SATURATE && (exact < PMIN)) begin
        psum_d = PMIN[PSUM_WIDTH-1:0];
        sat_d  = 1'b1;
      end else begin
        psum_d = exact[PSUM_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      cnt_q        <= '0;
      weights_q    <= '{default: '0};
      wfwd_valid_q <= 1'b0;
      wfwd_q       <= '0;
      valid_q      <= 1'b0;
      ifmap_q      <= '0;
      psum_q       <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      weights_q    <= weights_d;
      wfwd_valid_q <= wfwd_valid_d;
      wfwd_q       <= wfwd_d;
      valid_q      <= valid_d;
      ifmap_q      <= ifmap_d;
      psum_q       <= psum_d;
      sat_q        <= sat_d;
    end
  end

  assign chain_o.wload_valid = wfwd_valid_q;
  assign chain_o.weight      = wfwd_q;
  assign chain_o.valid       = valid_q;
  assign chain_o.ifmap       = ifmap_q;
  assign chain_o.psum        = psum_q;
  assign sat_o               = sat_q;
  assign ready_o             = (state_q == READY);

endmodule
